// File: rtl/packet_stream_generator_pkg.sv
// Shared types and helpers for the packet stream generator.
//   mode_e      : payload mode (incrementing, LFSR, constant)
//   state_e     : generator FSM state
//   LFSR_TAPS   : tap mask for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
//   lfsr_step   : one Fibonacci shift of the 32-bit LFSR
//   decode_mode : maps the raw 2-bit mode field onto mode_e (3 folds to MODE_INC)
package packet_stream_generator_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_LFSR;
            2'd2:    return MODE_CONST;
            default: return MODE_INC;
        endcase
    endfunction

endpackage

// File: rtl/packet_stream_generator_if.sv
// Framed stream link between the generator and its downstream consumer.
//   out_data  : payload beat
//   out_valid : beat present
//   out_sop   : first beat of a packet
//   out_eop   : last beat of a packet
//   in_busy   : downstream stall; a beat is taken when out_valid && !in_busy
interface packet_stream_generator_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_sop;
    logic                  out_eop;
    logic                  in_busy;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  in_busy
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output in_busy
    );
endinterface

// File: rtl/pkt_gen_lfsr.sv
// 32-bit Fibonacci LFSR used as the pseudo-random payload source.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset, loads LFSR_SEED
//   advance : shift by one step this edge
//   state   : current LFSR contents
module pkt_gen_lfsr
    import packet_stream_generator_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2021
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    output logic [31:0] state
);

    // An all-zero seed would lock the register at zero forever.
    if (LFSR_SEED == 32'h0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/packet_stream_generator.sv
// Test-stream source producing framed packets with configurable length, payload mode and
// inter-packet gap. Backpressure holds the current beat; nothing is dropped.
//   clk, reset_n  : rising-edge clock, synchronous active-low reset
//   enable        : generate packets continuously while high
//   cfg_mode      : 0 incrementing, 1 LFSR, 2 constant, 3 as 0
//   cfg_len       : words per packet (0 means 1)
//   cfg_gap       : idle cycles between eop acceptance and next sop
//   cfg_const     : payload for constant mode
//   stream        : framed output stream (master side)
//   pkt_count     : completed packets, wrapping
//   idle          : FSM is idle
module packet_stream_generator
    import packet_stream_generator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned GAP_WIDTH  = 8,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2021
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [1:0]            cfg_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_const,
    packet_stream_generator_if.master stream,
    output logic [15:0]           pkt_count,
    output logic                  idle
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
        $error("DATA_WIDTH must be in 1..32");
    end

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] const_q, const_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic                  idle_q, idle_d;

    logic                  beat_accept;
    logic                  eop_accept;
    logic                  gap_done;
    logic                  start_pkt;
    logic                  lfsr_adv;
    logic [31:0]           lfsr_state;
    logic [31:0]           lfsr_after;
    logic [LEN_WIDTH-1:0]  cfg_len_eff;
    logic [LEN_WIDTH-1:0]  idx_next;
    logic [LEN_WIDTH-1:0]  len_last;

    function automatic logic [DATA_WIDTH-1:0] beat_data(
        input mode_e                 mode,
        input logic [LEN_WIDTH-1:0]  idx,
        input logic [31:0]           lfsr,
        input logic [DATA_WIDTH-1:0] cst
    );
        case (mode)
            MODE_LFSR:  return DATA_WIDTH'(lfsr);
            MODE_CONST: return cst;
            default:    return DATA_WIDTH'(idx);
        endcase
    endfunction

    assign beat_accept = (state_q == StSend) && valid_q && !stream.in_busy;
    assign eop_accept  = beat_accept && eop_q;
    assign gap_done    = (gap_cnt_q == gap_q);
    assign lfsr_adv    = beat_accept && (mode_q == MODE_LFSR);
    assign cfg_len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign idx_next    = idx_q + LEN_WIDTH'(1);
    assign len_last    = len_q - LEN_WIDTH'(1);

    // A packet starts on every entry into SEND, including SEND->SEND back-to-back.
    assign start_pkt   = (state_d == StSend) && ((state_q != StSend) || eop_accept);

    pkt_gen_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StSend;
            end
            StSend: begin
                if (eop_accept) begin
                    if (gap_q != '0)  state_d = StGap;
                    else if (!enable) state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_done) state_d = enable ? StSend : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        // Registered outputs need the LFSR value the next beat will see.
        lfsr_after  = lfsr_adv ? lfsr_step(lfsr_state) : lfsr_state;
        mode_d      = mode_q;
        len_d       = len_q;
        gap_d       = gap_q;
        const_d     = const_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        data_d      = data_q;
        pkt_count_d = pkt_count_q;
        idle_d      = (state_d == StIdle);

        if (eop_accept) begin
            pkt_count_d = pkt_count_q + 16'd1;
            gap_cnt_d   = GAP_WIDTH'(1);
            idx_d       = '0;
            valid_d     = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            data_d      = '0;
        end else if (beat_accept) begin
            idx_d  = idx_next;
            sop_d  = 1'b0;
            eop_d  = (idx_next == len_last);
            data_d = beat_data(mode_q, idx_next, lfsr_after, const_q);
        end

        if ((state_q == StGap) && !gap_done) begin
            gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
        end

        // Config is captured only here, so mid-packet changes wait for the next sop.
        if (start_pkt) begin
            mode_d  = decode_mode(cfg_mode);
            len_d   = cfg_len_eff;
            gap_d   = cfg_gap;
            const_d = cfg_const;
            idx_d   = '0;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (cfg_len_eff == LEN_WIDTH'(1));
            data_d  = beat_data(decode_mode(cfg_mode), '0, lfsr_after, cfg_const);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q      <= MODE_INC;
            len_q       <= LEN_WIDTH'(1);
            gap_q       <= '0;
            const_q     <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            data_q      <= '0;
            pkt_count_q <= '0;
            idle_q      <= 1'b1;
        end else begin
            mode_q      <= mode_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            const_q     <= const_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            data_q      <= data_d;
            pkt_count_q <= pkt_count_d;
            idle_q      <= idle_d;
        end
    end

    assign stream.out_data  = data_q;
    assign stream.out_valid = valid_q;
    assign stream.out_sop   = sop_q;
    assign stream.out_eop   = eop_q;
    assign pkt_count        = pkt_count_q;
    assign idle             = idle_q;

endmodule

// File: tb/tb_packet_stream_generator.sv
module tb_packet_stream_generator;

    localparam logic [31:0] SEED = 32'hACE1_2021;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_len;
    logic [7:0]  cfg_gap;
    logic [7:0]  cfg_const;
    logic [15:0] pkt_count;
    logic        idle;

    packet_stream_generator_if #(.DATA_WIDTH(8)) sif ();

    packet_stream_generator #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8),
        .GAP_WIDTH  (8),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cfg_mode  (cfg_mode),
        .cfg_len   (cfg_len),
        .cfg_gap   (cfg_gap),
        .cfg_const (cfg_const),
        .stream    (sif),
        .pkt_count (pkt_count),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: outputs sampled at the falling edge plus the inputs presented
    // for the following rising edge.
    typedef struct {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [7:0]  data;
        logic        busy;
        logic        idle;
        logic [15:0] cnt;
        logic [1:0]  mode;
        logic [7:0]  len;
        logic [7:0]  gap;
        logic [7:0]  cst;
    } cyc_t;

    cyc_t        log_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_lfsr;

    // Reference LFSR step taken straight from the polynomial x^32+x^22+x^2+x+1.
    function automatic logic [31:0] ref_lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [10:0] beat_of(input int t);
        return {log_q[t].valid, log_q[t].sop, log_q[t].eop, log_q[t].data};
    endfunction

    task automatic tick(input logic busy);
        cyc_t c;
        sif.in_busy = busy;
        c.valid = sif.out_valid;
        c.sop   = sif.out_sop;
        c.eop   = sif.out_eop;
        c.data  = sif.out_data;
        c.busy  = busy;
        c.idle  = idle;
        c.cnt   = pkt_count;
        c.mode  = cfg_mode;
        c.len   = cfg_len;
        c.gap   = cfg_gap;
        c.cst   = cfg_const;
        log_q.push_back(c);
        @(negedge clk);
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reset_n = 1'b1;
        model_lfsr = SEED;
        log_q.delete();
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] l, input logic [7:0] g,
                           input logic [7:0] c);
        cfg_mode  = m;
        cfg_len   = l;
        cfg_gap   = g;
        cfg_const = c;
    endtask

    task automatic test_reset();
        do_reset();
        set_cfg(2'd2, 8'd8, 8'd0, 8'hA5);
        enable = 1'b1;
        repeat (3) tick(1'b0);
        reset_n = 1'b0;
        tick(1'b0);
        checks++; if (sif.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0", sif.out_valid); end
        checks++; if (sif.out_sop !== 1'b0) begin errors++;
            $display("FAIL reset_sop: got %b expected 0", sif.out_sop); end
        checks++; if (sif.out_eop !== 1'b0) begin errors++;
            $display("FAIL reset_eop: got %b expected 0", sif.out_eop); end
        checks++; if (sif.out_data !== 8'h00) begin errors++;
            $display("FAIL reset_data: got %h expected 00", sif.out_data); end
        checks++; if (pkt_count !== 16'd0) begin errors++;
            $display("FAIL reset_count: got %0d expected 0", pkt_count); end
        checks++; if (idle !== 1'b1) begin errors++;
            $display("FAIL reset_idle: got %b expected 1", idle); end
        reset_n = 1'b1;
        enable  = 1'b0;
        repeat (3) tick(1'b0);
        checks++; if ({idle, sif.out_valid} !== 2'b10) begin errors++;
            $display("FAIL reset_stay_idle: got %b expected 10", {idle, sif.out_valid}); end
    endtask

    task automatic test_inc_basic();
        logic [10:0] exp_tab[$];
        do_reset();
        set_cfg(2'd0, 8'd4, 8'd2, 8'h00);
        enable = 1'b1;
        repeat (13) tick(1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) exp_tab.push_back({1'b1, i == 0, i == 3, 8'(i)});
            for (int g = 0; g < 2; g++) exp_tab.push_back(11'h000);
        end
        checks++; if (log_q[0].valid !== 1'b0) begin errors++;
            $display("FAIL inc_pre_start: got %b expected 0", log_q[0].valid); end
        for (int k = 0; k < exp_tab.size(); k++) begin
            checks++;
            if (beat_of(k + 1) !== exp_tab[k]) begin errors++;
                $display("FAIL inc_beat[%0d]: got %h expected %h", k + 1, beat_of(k + 1),
                         exp_tab[k]); end
        end
        checks++; if (log_q[5].cnt !== 16'd1) begin errors++;
            $display("FAIL inc_count1: got %0d expected 1", log_q[5].cnt); end
        checks++; if (log_q[11].cnt !== 16'd2) begin errors++;
            $display("FAIL inc_count2: got %0d expected 2", log_q[11].cnt); end
    endtask

    task automatic test_backpressure();
        logic        busy_tab[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        logic [10:0] exp_tab[8] = '{11'h600, 11'h401, 11'h401, 11'h401, 11'h401, 11'h502,
                                    11'h000, 11'h000};
        int          nacc;
        logic [7:0]  acc_data[$];
        do_reset();
        set_cfg(2'd0, 8'd3, 8'd2, 8'h00);
        enable = 1'b1;
        for (int t = 0; t < 9; t++) begin
            if (t == 6) enable = 1'b0;
            tick(busy_tab[t]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (beat_of(k + 1) !== exp_tab[k]) begin errors++;
                $display("FAIL stall_beat[%0d]: got %h expected %h", k + 1, beat_of(k + 1),
                         exp_tab[k]); end
        end
        nacc = 0;
        for (int t = 0; t < 9; t++) begin
            if (log_q[t].valid && !log_q[t].busy) begin
                acc_data.push_back(log_q[t].data);
                nacc++;
            end
        end
        checks++; if (nacc !== 3) begin errors++;
            $display("FAIL stall_accept_count: got %0d expected 3", nacc); end
        for (int k = 0; k < nacc && k < 3; k++) begin
            checks++;
            if (acc_data[k] !== 8'(k)) begin errors++;
                $display("FAIL stall_accept_data[%0d]: got %h expected %h", k, acc_data[k],
                         8'(k)); end
        end
    endtask

    task automatic test_lfsr();
        logic [31:0] lf;
        do_reset();
        set_cfg(2'd1, 8'd1, 8'd0, 8'h00);
        enable = 1'b1;
        for (int t = 0; t < 60; t++) tick($urandom_range(0, 3) == 0);
        lf = model_lfsr;
        for (int t = 1; t < 60; t++) begin
            checks++;
            if ({log_q[t].valid, log_q[t].sop, log_q[t].eop} !== 3'b111) begin errors++;
                $display("FAIL lfsr_frame[%0d]: got %b expected 111", t,
                         {log_q[t].valid, log_q[t].sop, log_q[t].eop}); end
            checks++;
            if (log_q[t].data !== lf[7:0]) begin errors++;
                $display("FAIL lfsr_data[%0d]: got %h expected %h", t, log_q[t].data,
                         lf[7:0]); end
            if (!log_q[t].busy) lf = ref_lfsr_step(lf);
        end
    endtask

    task automatic test_const_len();
        logic [10:0] exp_tab[10] = '{11'h75A, 11'h75A, 11'h75A, 11'h65A, 11'h45A, 11'h45A,
                                     11'h45A, 11'h55A, 11'h7A5, 11'h7A5};
        do_reset();
        set_cfg(2'd2, 8'd0, 8'd0, 8'h5A);
        enable = 1'b1;
        for (int t = 0; t < 11; t++) begin
            if (t == 3) cfg_len = 8'd5;
            if (t == 5) begin
                cfg_len   = 8'd0;
                cfg_const = 8'hA5;
            end
            tick(1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (beat_of(k + 1) !== exp_tab[k]) begin errors++;
                $display("FAIL const_beat[%0d]: got %h expected %h", k + 1, beat_of(k + 1),
                         exp_tab[k]); end
        end
        checks++; if (log_q[10].cnt !== 16'd5) begin errors++;
            $display("FAIL const_count: got %0d expected 5", log_q[10].cnt); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        set_cfg(2'd0, 8'd6, 8'd3, 8'h00);
        enable = 1'b1;
        for (int t = 0; t < 15; t++) begin
            if (t == 3)  enable = 1'b0;
            if (t == 12) enable = 1'b1;
            tick(1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (beat_of(i + 1) !== {1'b1, i == 0, i == 5, 8'(i)}) begin errors++;
                $display("FAIL drop_beat[%0d]: got %h expected %h", i + 1, beat_of(i + 1),
                         {1'b1, i == 0, i == 5, 8'(i)}); end
        end
        for (int t = 7; t <= 12; t++) begin
            checks++;
            if (log_q[t].valid !== 1'b0) begin errors++;
                $display("FAIL drop_no_sop[%0d]: got %b expected 0", t, log_q[t].valid); end
        end
        checks++; if (log_q[9].idle !== 1'b0) begin errors++;
            $display("FAIL drop_gap_busy: got %b expected 0", log_q[9].idle); end
        checks++; if (log_q[10].idle !== 1'b1) begin errors++;
            $display("FAIL drop_idle: got %b expected 1", log_q[10].idle); end
        checks++; if (beat_of(13) !== 11'h600) begin errors++;
            $display("FAIL drop_restart_sop: got %h expected 600", beat_of(13)); end
        checks++; if (beat_of(14) !== 11'h401) begin errors++;
            $display("FAIL drop_restart_next: got %h expected 401", beat_of(14)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cfg(2'd0, 8'd1, 8'd0, 8'h00);
        enable = 1'b1;
        for (int t = 0; t < 9; t++) begin
            if (t == 1) cfg_len = 8'd8;
            if (t == 5) reset_n = 1'b0;
            if (t == 6) reset_n = 1'b1;
            tick(1'b0);
        end
        checks++; if (beat_of(5) !== 11'h403) begin errors++;
            $display("FAIL rmid_before: got %h expected 403", beat_of(5)); end
        checks++; if (log_q[5].cnt !== 16'd1) begin errors++;
            $display("FAIL rmid_count_before: got %0d expected 1", log_q[5].cnt); end
        checks++; if (beat_of(6) !== 11'h000) begin errors++;
            $display("FAIL rmid_abort: got %h expected 000", beat_of(6)); end
        checks++; if ({log_q[6].cnt, log_q[6].idle} !== {16'd0, 1'b1}) begin errors++;
            $display("FAIL rmid_state: got cnt=%0d idle=%b expected cnt=0 idle=1",
                     log_q[6].cnt, log_q[6].idle); end
        checks++; if (beat_of(7) !== 11'h600) begin errors++;
            $display("FAIL rmid_restart: got %h expected 600", beat_of(7)); end
        checks++; if (beat_of(8) !== 11'h401) begin errors++;
            $display("FAIL rmid_next: got %h expected 401", beat_of(8)); end
    endtask

    // Random config every cycle and random stalls; the model tracks packets, gaps and the
    // LFSR at the transaction level.
    task automatic test_random();
        localparam int N = 400;
        logic [31:0] lf;
        logic [7:0]  exp_data;
        logic [7:0]  cst_l;
        int          idx, len_l, gap_l, mode_l, next_sop, pkts;
        bit          in_pkt;
        do_reset();
        enable = 1'b1;
        for (int t = 0; t < N; t++) begin
            set_cfg(2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)),
                    8'($urandom_range(0, 3)), 8'($urandom));
            tick($urandom_range(0, 2) == 0);
        end
        lf = model_lfsr;
        in_pkt = 0; next_sop = 1; pkts = 0; idx = 0;
        len_l = 1; gap_l = 0; mode_l = 0; cst_l = 8'h00;
        for (int t = 1; t < N; t++) begin
            checks++;
            if (log_q[t].cnt !== 16'(pkts)) begin errors++;
                $display("FAIL rand_count[%0d]: got %0d expected %0d", t, log_q[t].cnt, pkts);
            end
            if (!in_pkt) begin
                checks++;
                if (log_q[t].valid !== (t == next_sop)) begin errors++;
                    $display("FAIL rand_gap[%0d]: got valid=%b expected %b", t,
                             log_q[t].valid, t == next_sop); end
                if (t == next_sop) begin
                    in_pkt = 1;
                    idx    = 0;
                    len_l  = (log_q[t-1].len == 8'd0) ? 1 : int'(log_q[t-1].len);
                    gap_l  = int'(log_q[t-1].gap);
                    mode_l = (log_q[t-1].mode == 2'd3) ? 0 : int'(log_q[t-1].mode);
                    cst_l  = log_q[t-1].cst;
                end
            end
            if (in_pkt) begin
                exp_data = (mode_l == 1) ? lf[7:0] : (mode_l == 2) ? cst_l : 8'(idx);
                checks++;
                if (beat_of(t) !== {1'b1, idx == 0, idx == len_l - 1, exp_data}) begin
                    errors++;
                    $display("FAIL rand_beat[%0d]: got %h expected %h", t, beat_of(t),
                             {1'b1, idx == 0, idx == len_l - 1, exp_data}); end
                if (!log_q[t].busy) begin
                    if (mode_l == 1) lf = ref_lfsr_step(lf);
                    idx++;
                    if (idx == len_l) begin
                        in_pkt   = 0;
                        pkts++;
                        next_sop = t + gap_l + 1;
                    end
                end
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        sif.in_busy = 1'b0;
        set_cfg(2'd0, 8'd1, 8'd0, 8'h00);
        model_lfsr  = SEED;
        @(negedge clk);
        test_reset();
        test_inc_basic();
        test_backpressure();
        test_lfsr();
        test_const_len();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
